// File: rtl/icache_pkg.sv
// Shared types, default geometry and address field helpers
// for the line instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        ABORT
    } state_t;

    localparam int DEF_INDEX_BITS  = 6;
    localparam int DEF_OFFSET_BITS = 2;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int TAG_BITS =
        DEF_ADDR_WIDTH - DEF_INDEX_BITS - DEF_OFFSET_BITS - 2;
    localparam int LINE_WORDS = 1 << DEF_OFFSET_BITS;

    function automatic logic [31:0] addr_field(
        input logic [31:0] a,
        input int          lsb,
        input int          bits
    );
        logic [31:0] m;
        m = (32'd1 << bits) - 32'd1;
        return (a >> lsb) & m;
    endfunction

endpackage

// File: rtl/line_instruction_cache_if.sv
// Fetch-side and memory-adaptor-side signals of the cache.
// slave = cache, master = fetch unit / adaptor side.
interface line_instruction_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  flush_pipline;
    logic                  invalidate_all;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  is_reading;
    logic [31:0]           read_data;
    logic                  is_ready;
    logic                  icache_available;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;
    logic                  mem_done;

    modport slave (
        input  flush_pipline, invalidate_all,
        input  read_addr, is_reading,
        input  mem_data, mem_done,
        output read_data, is_ready, icache_available,
        output mem_req, mem_addr
    );

    modport master (
        output flush_pipline, invalidate_all,
        output read_addr, is_reading,
        output mem_data, mem_done,
        input  read_data, is_ready, icache_available,
        input  mem_req, mem_addr
    );
endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational read, one word write,
// tag+valid write per line, bulk valid clear.
module icache_line_store #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_W       = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  rd_idx,
    input  logic [OFFSET_BITS-1:0] rd_off,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [31:0]            rd_word,
    input  logic                   word_we,
    input  logic [INDEX_BITS-1:0]  word_idx,
    input  logic [OFFSET_BITS-1:0] word_off,
    input  logic [31:0]            word_data,
    input  logic                   line_we,
    input  logic [INDEX_BITS-1:0]  line_idx,
    input  logic [TAG_W-1:0]       line_tag,
    input  logic                   line_valid,
    input  logic                   clear_all
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][WORDS];

    // Bulk clear wins over a same-cycle line validation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (clear_all)
            valid <= '0;
        else if (line_we)
            valid[line_idx] <= line_valid;
    end

    always_ff @(posedge clk) begin
        if (line_we)
            tags[line_idx] <= line_tag;
        if (word_we)
            data[word_idx][word_off] <= word_data;
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_word  = data[rd_idx][rd_off];

endmodule

// File: rtl/line_instruction_cache.sv
// Direct-mapped instruction cache, multi-word lines,
// critical-word-first refill, fence.i bulk invalidate.
module line_instruction_cache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    line_instruction_cache_if.slave bus
);
    import icache_pkg::*;

    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

    state_t                 state, state_nx;
    logic [INDEX_BITS-1:0]  idx_q, req_idx, line_idx;
    logic [TAG_W-1:0]       tag_q, req_tag, rd_tag;
    logic [OFFSET_BITS-1:0] start_q, cnt_q, cnt_nx;
    logic [OFFSET_BITS-1:0] req_off, cur_off;
    logic                   kill_q, kill_nx;
    logic                   rd_valid, hit;
    logic [31:0]            rd_word, rdata;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   ready, req;
    logic                   word_we, line_we, line_valid;

    assign req_off = OFFSET_BITS'(addr_field(32'(bus.read_addr),
                                             2, OFFSET_BITS));
    assign req_idx = INDEX_BITS'(addr_field(32'(bus.read_addr),
                                            OFFSET_BITS + 2, INDEX_BITS));
    assign req_tag = TAG_W'(addr_field(32'(bus.read_addr),
                                       INDEX_BITS + OFFSET_BITS + 2, TAG_W));
    assign cur_off  = start_q + cnt_q;
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign line_idx = (state == IDLE) ? req_idx : idx_q;

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_W      (TAG_W)
    ) store (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .rd_idx    (req_idx),
        .rd_off    (req_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .word_we   (word_we && rdy_in),
        .word_idx  (idx_q),
        .word_off  (cur_off),
        .word_data (bus.mem_data),
        .line_we   (line_we && rdy_in),
        .line_idx  (line_idx),
        .line_tag  (tag_q),
        .line_valid(line_valid),
        .clear_all (bus.invalidate_all && rdy_in)
    );

    always_comb begin
        state_nx   = state;
        kill_nx    = kill_q;
        cnt_nx     = cnt_q;
        ready      = 1'b0;
        req        = 1'b0;
        rdata      = rd_word;
        addr       = {tag_q, idx_q, cur_off, 2'b00};
        word_we    = 1'b0;
        line_we    = 1'b0;
        line_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.is_reading && !bus.flush_pipline) begin
                    if (hit) begin
                        ready = 1'b1;
                    end else begin
                        req      = 1'b1;
                        addr     = {bus.read_addr[ADDR_WIDTH-1:2], 2'b00};
                        line_we  = 1'b1;
                        cnt_nx   = '0;
                        kill_nx  = bus.invalidate_all;
                        state_nx = REFILL;
                    end
                end
            end
            REFILL: begin
                req = 1'b1;
                if (bus.invalidate_all)
                    kill_nx = 1'b1;
                if (bus.flush_pipline) begin
                    kill_nx  = 1'b1;
                    state_nx = bus.mem_done ? IDLE : ABORT;
                end else if (bus.mem_done) begin
                    word_we = 1'b1;
                    rdata   = bus.mem_data;
                    ready   = (cnt_q == '0);
                    cnt_nx  = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        line_we    = 1'b1;
                        line_valid = !kill_q && !bus.invalidate_all;
                        state_nx   = IDLE;
                    end
                end
            end
            ABORT: begin
                if (bus.mem_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            idx_q   <= '0;
            tag_q   <= '0;
            start_q <= '0;
        end else if (rdy_in) begin
            state  <= state_nx;
            cnt_q  <= cnt_nx;
            kill_q <= kill_nx;
            if (state == IDLE && state_nx == REFILL) begin
                idx_q   <= req_idx;
                tag_q   <= req_tag;
                start_q <= req_off;
            end
        end
    end

    // Outputs are forced quiet while reset is held.
    assign bus.is_ready = ready && rdy_in && rst_in;
    assign bus.mem_req  = req && rst_in && (rdy_in || state != IDLE);
    assign bus.icache_available = (state == IDLE) && rst_in;
    assign bus.read_data = rdata;
    assign bus.mem_addr  = addr;

endmodule

// File: tb/tb_line_instruction_cache.sv
// Randomized bench: transaction-level cache model plus a
// latency-programmable memory adaptor.
module tb_line_instruction_cache;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   vecs = 0;
    int   errs = 0;

    bit          mv [64];
    logic [21:0] mt [64];

    line_instruction_cache_if #(.ADDR_WIDTH(32)) bus ();

    line_instruction_cache #(
        .INDEX_BITS (6),
        .OFFSET_BITS(2),
        .ADDR_WIDTH (32)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .rdy_in(rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] waddr(input logic [31:0] a,
                                          input logic [1:0] off,
                                          input int k);
        logic [1:0] o;
        o = off + 2'(k);
        return {a[31:4], o, 2'b00};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = '0;
        a[11:10] = 2'($urandom_range(0, 2));
        a[5:4]   = 2'($urandom_range(0, 3));
        a[3:0]   = 4'($urandom);
        return a;
    endfunction

    task automatic clear_model();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic idle_in();
        bus.is_reading     = 1'b0;
        bus.flush_pipline  = 1'b0;
        bus.invalidate_all = 1'b0;
        bus.mem_done       = 1'b0;
        rdy                = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a, input int lat,
                         input int fl, input int iv,
                         input int st, input int stn);
        int          idx, k, wait_c, cyc;
        logic [21:0] tg;
        logic [1:0]  off;
        bit          abrt, kill, fnow, inow, r, done, fin, crit;
        idx = int'(a[9:4]);
        tg  = a[31:10];
        off = a[3:2];
        @(posedge clk); #1;
        bus.is_reading = 1'b1;
        bus.read_addr  = a;
        @(negedge clk);
        if (mv[idx] && mt[idx] == tg) begin
            chk("hit_rdy", 32'(bus.is_ready), 1);
            chk("hit_data", bus.read_data, memfn(a));
            chk("hit_req", 32'(bus.mem_req), 0);
        end else begin
            chk("miss_rdy", 32'(bus.is_ready), 0);
            chk("miss_req", 32'(bus.mem_req), 1);
            chk("miss_addr", bus.mem_addr, waddr(a, off, 0));
            mv[idx] = 1'b0;
            k = 0; wait_c = lat; cyc = 0;
            abrt = 0; kill = 0; fin = 0;
            while (!fin) begin
                @(posedge clk); #1;
                fnow = (cyc == fl);
                inow = (cyc == iv);
                r = fnow || inow ||
                    !(st >= 0 && cyc >= st && cyc < st + stn);
                rdy                = r;
                bus.flush_pipline  = fnow;
                bus.invalidate_all = inow;
                bus.is_reading     = 1'($urandom_range(0, 1));
                bus.read_addr      = $urandom;
                done = 0;
                if (r) begin
                    wait_c--;
                    done = (wait_c == 0);
                end
                bus.mem_done = done;
                bus.mem_data = done ? memfn(waddr(a, off, k)) : $urandom;
                @(negedge clk);
                if (abrt) begin
                    chk("abort_req", 32'(bus.mem_req), 0);
                    chk("abort_avail", 32'(bus.icache_available), 0);
                end else begin
                    chk("refill_req", 32'(bus.mem_req), 1);
                    chk("refill_addr", bus.mem_addr, waddr(a, off, k));
                end
                crit = done && k == 0 && !fnow && !abrt;
                chk("refill_rdy", 32'(bus.is_ready), 32'(crit));
                if (crit)
                    chk("crit_data", bus.read_data, memfn(a));
                if (inow) begin
                    clear_model();
                    kill = 1;
                end
                if (abrt) begin
                    fin = done;
                end else if (fnow) begin
                    if (done) fin = 1;
                    else abrt = 1;
                end else if (done) begin
                    k++;
                    wait_c = lat + 1;
                    if (k == 4) begin
                        fin = 1;
                        if (!kill) begin
                            mv[idx] = 1'b1;
                            mt[idx] = tg;
                        end
                    end
                end
                cyc++;
                if (cyc > 500) begin
                    chk("refill_timeout", 0, 1);
                    fin = 1;
                end
            end
        end
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("avail", 32'(bus.icache_available), 1);
    endtask

    task automatic inval();
        @(posedge clk); #1;
        bus.invalidate_all = 1'b1;
        @(negedge clk);
        chk("inv_avail", 32'(bus.icache_available), 1);
        @(posedge clk); #1;
        bus.invalidate_all = 1'b0;
        clear_model();
    endtask

    task automatic idle_flush(input logic [31:0] a);
        @(posedge clk); #1;
        bus.is_reading    = 1'b1;
        bus.flush_pipline = 1'b1;
        bus.read_addr     = a;
        @(negedge clk);
        chk("iflush_rdy", 32'(bus.is_ready), 0);
        chk("iflush_req", 32'(bus.mem_req), 0);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("iflush_avail", 32'(bus.icache_available), 1);
    endtask

    task automatic stalled_hit(input logic [31:0] a);
        @(posedge clk); #1;
        rdy            = 1'b0;
        bus.is_reading = 1'b1;
        bus.read_addr  = a;
        @(negedge clk);
        chk("stall_rdy", 32'(bus.is_ready), 0);
        chk("stall_req", 32'(bus.mem_req), 0);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("stall_avail", 32'(bus.icache_available), 1);
    endtask

    task automatic reset_mid(input logic [31:0] a);
        @(posedge clk); #1;
        bus.is_reading = 1'b1;
        bus.read_addr  = a;
        @(negedge clk);
        chk("rm_req0", 32'(bus.mem_req), 1);
        @(posedge clk); #1;
        bus.is_reading = 1'b0;
        @(negedge clk);
        chk("rm_req1", 32'(bus.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_req_rst", 32'(bus.mem_req), 0);
        chk("rm_avail_rst", 32'(bus.icache_available), 0);
        chk("rm_rdy_rst", 32'(bus.is_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        chk("rm_avail1", 32'(bus.icache_available), 1);
    endtask

    initial begin
        int op, fl, iv, st;
        rst_n             = 1'b0;
        idle_in();
        bus.is_reading    = 1'b1;
        bus.read_addr     = 32'h104;
        bus.mem_data      = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_rdy", 32'(bus.is_ready), 0);
        chk("rst_avail", 32'(bus.icache_available), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.is_reading = 1'b0;
        @(negedge clk);
        chk("rst_avail1", 32'(bus.icache_available), 1);

        fetch(32'h104, 3, -1, -1, -1, 0);
        fetch(32'h100, 3, -1, -1, -1, 0);
        fetch(32'h10C, 3, -1, -1, -1, 0);
        fetch(32'h000, 2, -1, -1, -1, 0);
        fetch(32'h400, 2, -1, -1, -1, 0);
        fetch(32'h000, 2, -1, -1, -1, 0);
        fetch(32'h300, 3, 0, -1, -1, 0);
        fetch(32'h300, 3, -1, -1, -1, 0);
        fetch(32'h700, 3, 2, -1, -1, 0);
        fetch(32'h700, 1, -1, -1, -1, 0);
        fetch(32'h200, 3, -1, 4, -1, 0);
        fetch(32'h200, 3, -1, -1, -1, 0);
        fetch(32'h104, 2, -1, -1, -1, 0);
        fetch(32'h508, 2, -1, -1, 3, 5);
        fetch(32'h500, 2, -1, -1, -1, 0);
        idle_flush(32'h504);
        stalled_hit(32'h504);
        fetch(32'h504, 2, -1, -1, -1, 0);
        reset_mid(32'h600);
        fetch(32'h500, 2, -1, -1, -1, 0);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 19);
            if (op == 0) begin
                inval();
            end else if (op == 1) begin
                idle_flush(rand_addr());
            end else if (op == 2) begin
                stalled_hit(rand_addr());
            end else begin
                fl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
                iv = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
                st = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1;
                fetch(rand_addr(), $urandom_range(1, 4), fl, iv, st,
                      $urandom_range(1, 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/line_instruction_cache.md
# line_instruction_cache

Parametrised direct-mapped instruction cache with multi-word lines, valid bits, critical-word-first refill and whole-cache invalidation. It sits between the instruction fetch unit and the memory adaptor and replaces the single-word instruction cache. Hits return data combinationally in the request cycle. A miss refills the whole line through sequential single-word transactions to the memory adaptor.

## Interface
- INDEX_BITS, 6, log2 of line count (64 lines)
- OFFSET_BITS, 2, log2 of words per line (4 words = 16 B)
- ADDR_WIDTH, 32, byte-address width; tag = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-2 bits
- clk_in  in  1  system clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state
- flush_pipline  in  1  abandon current request
- invalidate_all  in  1  clear every valid bit (fence.i)
- read_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- is_reading  in  1  fetch request, sampled only while icache_available=1
- read_data  out  32  instruction word, valid only while is_ready=1
- is_ready  out  1  one-cycle data strobe
- icache_available  out  1  new request may be issued this cycle
- mem_req  out  1  word request to memory adaptor
- mem_addr  out  ADDR_WIDTH  word-aligned address of requested word
- mem_data  in  32  word returned by adaptor
- mem_done  in  1  exactly one-cycle pulse per completed word

## Operation
- Storage per line: valid bit, tag, 2^OFFSET_BITS data words.
- States: IDLE, REFILL, ABORT.
- IDLE, is_reading, line valid and tag match (hit): is_ready=1, read_data=stored word, same cycle; no state change.
- IDLE, is_reading, miss: capture line base, index, tag, start offset = read_addr offset; counter=0; mem_req=1 and mem_addr=requested word in the same cycle; go REFILL. Clear the line's valid bit.
- REFILL: words fetched in order start, start+1, … mod 2^OFFSET_BITS (wrap within line). Each mem_done writes mem_data into that word and advances counter; mem_addr updates next cycle; mem_req stays high until last word done.
- First mem_done of a refill (critical word): is_ready=1, read_data=mem_data, that cycle.
- Last mem_done: write tag, set valid unless the kill flag is set; go IDLE.
- flush_pipline in REFILL: go ABORT; kill flag set; mem_req drops next cycle. ABORT waits for mem_done of the outstanding word, discards it, goes IDLE. flush coinciding with mem_done goes IDLE directly; no is_ready.
- flush_pipline in IDLE: suppresses is_ready and refill start that cycle.
- invalidate_all: all valid bits cleared at next edge; during REFILL also sets kill flag so the line in flight never becomes valid. Critical-word delivery still occurs.
- Kill flag cleared on entry to REFILL.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, all valid=0, kill=0, counter=0; outputs mem_req=0, is_ready=0, icache_available=0 while asserted, 1 first cycle after release.
- icache_available=1 only in IDLE.
- Hit latency 0 cycles; miss critical-word latency = adaptor latency; line busy until last of 2^OFFSET_BITS words.
- rdy_in=0: no register updates, is_ready=0, mem_req held; adaptor is frozen by the same signal, so mem_done is not expected.
- Tag/index/offset arithmetic unsigned, offset increment wraps modulo 2^OFFSET_BITS.
- Address tag 0 is legal; validity is defined only by valid bits.

## Structure
- Package icache_pkg: state enum (IDLE, REFILL, ABORT), derived widths TAG_BITS, LINE_WORDS, field-extract functions.
- Sub-module icache_line_store: valid/tag/data arrays, combinational read port, one word write port, tag+valid write, bulk valid clear.
- Top module holds FSM, counter, kill flag, output muxing.

## Test plan
- Cold miss at 0x0000_0104, adaptor 3-cycle latency -> mem_addr 0x104, 0x108, 0x10C, 0x100; is_ready on first mem_done with that word; then hit at 0x100 returns word in request cycle.
- Two addresses 0x0000_0000 and 0x0000_0400 (same index, default params) -> second evicts first; re-read of 0x0 misses.
- flush_pipline one cycle after miss start -> state ABORT, waits one mem_done, no is_ready, line remains invalid (next read misses).
- invalidate_all during refill of 0x200 -> critical word still delivered, refill completes, subsequent read of 0x200 misses; earlier cached lines also miss.
- rdy_in low for 5 cycles mid-refill -> mem_addr/counter unchanged, is_ready=0; resumes correctly.
- rst_in asserted mid-refill -> mem_req=0 immediately, after release all lines miss, icache_available=1.
